uart_rx: RTL and testbench

//   Asynchronous serial receiver, 8 data bits, LSB first, optional parity, 1 stop bit.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, one stop bit.
// Runtime clocks-per-bit divider with mid-bit sampling, sticky ready flag.
module uart_rx (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_ready_i,
  input  logic        parity_bit_i,
  input  logic        parity_even_i,
  input  logic        serial_i,
  input  logic [15:0] clock_divider_i,
  output logic [7:0]  data_o,
  output logic        ready_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [15:0] bit_div;
  logic [15:0] div_eff;
  logic [15:0] half_eff;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        par_en;
  logic        par_even;
  logic        par_err;
  logic        expire;
  logic        frame_good;

  // Divider values 0 and 1 both mean one clock per bit; half-bit is never below 1.
  always_comb begin
    div_eff  = (clock_divider_i == '0) ? 16'd1 : clock_divider_i;
    half_eff = (div_eff[15:1] == '0) ? 16'd1 : {1'b0, div_eff[15:1]};
  end

  assign expire = (cnt <= 16'd1);

  always_comb begin
    state_next = state;
    frame_good = 1'b0;
    case (state)
      IDLE:      if (!serial_i) state_next = START;
      START:     if (expire) state_next = serial_i ? IDLE : DATA;
      DATA:      if (expire && idx == 3'd7) state_next = par_en ? PARITY : STOP;
      PARITY:    if (expire) state_next = STOP;
      STOP: begin
        if (expire) begin
          if (serial_i) begin
            frame_good = !par_err;
            state_next = IDLE;
          end else begin
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (serial_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt      <= '0;
      bit_div  <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_even <= 1'b0;
      par_err  <= 1'b0;
      data_o   <= '0;
      ready_o  <= 1'b0;
    end else begin
      if (cnt > 16'd1) cnt <= cnt - 16'd1;
      case (state)
        IDLE: begin
          if (!serial_i) begin
            cnt      <= half_eff;
            bit_div  <= div_eff;
            par_en   <= parity_bit_i;
            par_even <= parity_even_i;
            par_err  <= 1'b0;
            idx      <= '0;
          end
        end
        START: if (expire) cnt <= bit_div;
        DATA: begin
          if (expire) begin
            shreg[idx] <= serial_i;
            idx        <= idx + 3'd1;
            cnt        <= bit_div;
          end
        end
        PARITY: begin
          if (expire) begin
            // Even parity needs XOR(data,parity)==0, odd needs 1.
            par_err <= (^shreg) ^ serial_i ^ ~par_even;
            cnt     <= bit_div;
          end
        end
        default: ;
      endcase
      // Frame completion wins over a simultaneous clear.
      if (frame_good) begin
        data_o  <= shreg;
        ready_o <= 1'b1;
      end else if (clear_ready_i) begin
        ready_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by randomized frames
// checked against a frame-level reference model (expected byte / ready flag).
module tb_uart_rx;

  logic        clock_i;
  logic        reset_i;
  logic        clear_ready_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic        serial_i;
  logic [15:0] clock_divider_i;
  logic [7:0]  data_o;
  logic        ready_o;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;

  logic [7:0] exp_data;
  logic       exp_ready;

  uart_rx dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .clear_ready_i  (clear_ready_i),
    .parity_bit_i   (parity_bit_i),
    .parity_even_i  (parity_even_i),
    .serial_i       (serial_i),
    .clock_divider_i(clock_divider_i),
    .data_o         (data_o),
    .ready_o        (ready_o)
  );

  initial clock_i = 1'b0;
  always #1 clock_i = ~clock_i;

  initial begin
    #150000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ready"}, {7'd0, ready_o}, {7'd0, exp_ready});
    check({tag, "_data"}, data_o, exp_data);
  endtask

  // Drive the line to v for n clocks; always entered and left on a negedge.
  task automatic hold(input logic v, input int n);
    serial_i = v;
    repeat (n) @(negedge clock_i);
  endtask

  task automatic pulse_clear();
    clear_ready_i = 1'b1;
    check("clear_before_edge", {7'd0, ready_o}, {7'd0, exp_ready});
    @(negedge clock_i);
    clear_ready_i = 1'b0;
    exp_ready = 1'b0;
    check_outputs("clear");
  endtask

  // One complete frame; the model decides acceptance from the frame's own contents.
  task automatic send_frame(input logic [7:0] b, input int d, input logic pen,
                            input logic peven, input logic bad_par,
                            input logic bad_stop, input logic clr_sync);
    int   h;
    logic pbit;
    logic good;
    h = (d / 2 < 1) ? 1 : d / 2;
    parity_bit_i    = pen;
    parity_even_i   = peven;
    clock_divider_i = d[15:0];
    hold(1'b0, d);
    for (int i = 0; i < 8; i++) hold(b[i], d);
    if (pen) begin
      pbit = peven ? ^b : ~^b;
      hold(pbit ^ bad_par, d);
    end
    good = !bad_stop && !(pen && bad_par);
    serial_i = !bad_stop;
    for (int k = 1; k <= d; k++) begin
      if (clr_sync && k == h + 1) clear_ready_i = 1'b1;
      @(negedge clock_i);
      clear_ready_i = 1'b0;
      if (k == 1) check_outputs("stop_not_yet");
    end
    if (good) begin
      exp_data  = b;
      exp_ready = 1'b1;
    end else if (clr_sync) begin
      exp_ready = 1'b0;
    end
    check_outputs("frame_end");
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    clear_ready_i   = 1'b0;
    parity_bit_i    = 1'b0;
    parity_even_i   = 1'b0;
    serial_i        = 1'b1;
    clock_divider_i = 16'd2;
    reset_i         = 1'b1;
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    repeat (3) @(negedge clock_i);
    check_outputs("reset");
    reset_i = 1'b0;
    hold(1'b1, 4);

    // D=2, no parity: 0x55 then clear, then 0xAA after two idle bits.
    send_frame(8'h55, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    hold(1'b1, 4);
    send_frame(8'hAA, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // D=16 even parity: good parity accepted, bad parity discarded.
    hold(1'b1, 16);
    send_frame(8'h03, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    hold(1'b1, 16);
    send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 16);

    // Start glitch of one clock is rejected.
    hold(1'b0, 1);
    hold(1'b1, 40);
    check_outputs("glitch");

    // Framing error, break, recovery with 0x5A.
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(1'b0, 48);
    check_outputs("break");
    hold(1'b1, 16);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 16);

    // Overrun, then a clear that coincides with frame completion.
    send_frame(8'h11, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 4);
    send_frame(8'h22, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 4);
    send_frame(8'h33, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 4);

    // Reset in the middle of a frame.
    clock_divider_i = 16'd4;
    hold(1'b0, 4);
    hold(1'b1, 4);
    hold(1'b0, 4);
    reset_i  = 1'b1;
    serial_i = 1'b1;
    @(negedge clock_i);
    reset_i   = 1'b0;
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    check_outputs("mid_reset");
    hold(1'b1, 8);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         d;
      logic       pen, peven, bad_par, bad_stop, clr_sync;
      b        = 8'($urandom);
      d        = int'($urandom_range(2, 12));
      pen      = 1'($urandom);
      peven    = 1'($urandom);
      bad_par  = ($urandom_range(0, 4) == 0);
      bad_stop = ($urandom_range(0, 5) == 0);
      clr_sync = ($urandom_range(0, 3) == 0);
      send_frame(b, d, pen, peven, bad_par, bad_stop, clr_sync);
      hold(1'b1, d * int'($urandom_range(1, 2)));
      if ($urandom_range(0, 2) == 0) pulse_clear();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
